cp0_irq_ctrl: RTL and testbench
===============================

# cp0_irq_ctrl

Parametrised system-control coprocessor (CP0) for the MIPS32 pipeline, sitting beside the M stage. It holds BadVAddr, Count, Compare, SR, Cause, EPC and a read-only PRId. It merges a configurable number of synchronised hardware interrupt lines with a prescaled, sticky timer interrupt, and arbitrates interrupt, exception, ERET and mtc0 writes every cycle.

## Interface
- NUM_HWINT, 6: external interrupt lines, 1..6; they map to Cause.IP[2+i], and unused IP bits read 0.
- SYNC_STAGES, 2: flop stages on each HWInt line; 0 means bypass (combinational).
- COUNT_DIV, 1: Count advances once every COUNT_DIV cycles, 1..256.
- PRID, 32'h0001_8000: constant returned for register 15.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  mtc0 write strobe.
- CP0ADD  in  5  register address for read and write.
- CP0In  in  32  mtc0 write data.
- CP0Out  out  32  read data: 8/9/11/12/13/14/15 map to their registers; any other address returns 0.
- EXLSet  in  1  synchronous exception from the M stage.
- ExcCodeIn  in  5  exception code.
- VPC  in  32  PC of the M-stage instruction.
- VAddr  in  32  faulting address.
- BDIn  in  1  the M-stage instruction is in a delay slot.
- HWInt  in  NUM_HWINT  raw level interrupt lines, asynchronous.
- EXLClr  in  1  ERET commit.
- EPCOut  out  32  current EPC.
- Req  out  1  take the handler this cycle; combinational.
- TimerIrq  out  1  sticky timer flag TI, for debug and the bridge.

## Operation
- Register fields:
  - SR: IE=[0], EXL=[1], IM=[15:8]; all other SR bits are read-only.
  - Cause: BD=[31], TI=[30], IP=[15:8], ExcCode=[6:2]. IP[1:0] is software interrupt and is writable. IP[7:2] is hardware status and read-only.
- IP[2+i] = sync(HWInt[i]). IP[7] also ORs in TI. Hardware IP bits are refreshed every cycle.
- Interrupt condition: int = IE & ~EXL & |(IP & IM), evaluated on the current IP register value.
- Req = int | EXLSet.
- Per-edge priority, highest first:
  1. int: EXL←1; ExcCode←0; BD←BDIn; EPC←BDIn ? VPC−4 : VPC.
  2. EXLSet: same as int but ExcCode←ExcCodeIn. BadVAddr←VAddr only if ExcCodeIn is 4 (AdEL) or 5 (AdES).
  3. EXLClr: EXL←0.
  4. en: write the addressed register. Writes to addresses 8 and 15 are ignored.
- Rules for writes that lose arbitration:
  - A losing mtc0 write is dropped entirely.
  - Exception: Count and Compare writes are independent of 1–3 and always take effect when en is high.
- Prescaler: a counter runs 0..COUNT_DIV−1. When it is at terminal, Count←Count+1, wrapping 0xFFFF_FFFF→0.
- A Count write loads CP0In and clears the prescaler. The write wins over an increment in the same cycle.
- Timer match: TI←1 on the edge where an increment makes Count equal to Compare. Loading Count via mtc0 never sets TI.
- TI stays set until a Compare write clears it. If a clear and a match occur in the same cycle, the clear wins.
- All arithmetic is 32-bit unsigned and modulo.

## Timing
- Reset values (async on reset_n low):
  - SR=0x0040_0000; Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0xFFFF_FFFF; TI=0; prescaler=0; sync flops=0.
  - Outputs: CP0Out is the mux of the reset values; EPCOut=0; Req=0; TimerIrq=0.
- HWInt to IP latency: SYNC_STAGES+1 edges. HWInt to Req: the same, provided IE=1, EXL=0 and the line is enabled in IM.
- Req is the same-cycle response to EXLSet. The EPC/EXL update is visible on the next edge. Req cannot re-fire for an interrupt, because EXL is then 1.
- A mtc0 result is readable on CP0Out the cycle after the write edge. A same-cycle read returns the old value.
- TI timing:
  - TI is visible on the edge after Count reaches Compare.
  - TI reaches IP[7] one edge later.
  - Req follows combinationally from IP[7].
- reset_n asserted mid-handler restores all reset values immediately, regardless of clk.

## Test plan
- Reset: drop reset_n with no clock → SR=0x0040_0000, Compare=0xFFFF_FFFF, Req=0. Release reset_n and read Count 5 cycles later with COUNT_DIV=1 → 5.
- Interrupt: with SR=0x0000_0401, pulse HWInt[0] high → Req=1 exactly 3 edges later (SYNC_STAGES=2). After the edge: EPC=VPC, ExcCode=0, EXL=1, Req=0. EXLClr → EXL=0 and Req=1 again while HWInt[0] stays high.
- Delay slot plus exception priority: assert EXLSet with ExcCodeIn=4, BDIn=1, VPC=0x3004, VAddr=0x1235, together with en writing EPC → EPC=0x3000, BadVAddr=0x1235, BD=1, and the EPC write is dropped.
- Timer: COUNT_DIV=4, Count←0, Compare←3, SR=0x8001 → TI=1 after 12 edges. TI is held while Count passes Compare. Writing Compare clears TI and drops Req.
- Wrap and collision: Count←0xFFFF_FFFF, Compare←0 → TI sets on wrap. A Compare write on the match edge → TI=0.
- Masking: with EXL=1 or IE=0 and all HWInt high → Req=0, and Cause.IP still shows the lines. Reading address 15 → PRID.

Source files
------------

// File: rtl/cp0_irq_ctrl.sv
// ============================================================================
// Module   : cp0_irq_ctrl
// Purpose  : MIPS32 CP0 beside the M stage: status/cause/EPC, prescaled
//            sticky timer and synchronised hardware interrupts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_irq_ctrl #(
    parameter int          NUM_HWINT   = 6,
    parameter int          SYNC_STAGES = 2,
    parameter int          COUNT_DIV   = 1,
    parameter logic [31:0] PRID        = 32'h0001_8000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [4:0]           CP0ADD,
    input  logic [31:0]          CP0In,
    output logic [31:0]          CP0Out,
    input  logic                 EXLSet,
    input  logic [4:0]           ExcCodeIn,
    input  logic [31:0]          VPC,
    input  logic [31:0]          VAddr,
    input  logic                 BDIn,
    input  logic [NUM_HWINT-1:0] HWInt,
    input  logic                 EXLClr,
    output logic [31:0]          EPCOut,
    output logic                 Req,
    output logic                 TimerIrq
);

    localparam int            PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] c_PRE_LAST = PW'(COUNT_DIV - 1);

    logic [31:0]          r_badvaddr;
    logic [31:0]          r_count;
    logic [31:0]          r_compare;
    logic [31:0]          r_epc;
    logic [PW-1:0]        r_pre;
    logic                 r_ie;
    logic                 r_exl;
    logic [7:0]           r_im;
    logic                 r_bd;
    logic                 r_ti;
    logic [5:0]           r_ip_hw;
    logic [1:0]           r_ip_sw;
    logic [4:0]           r_exccode;

    logic [NUM_HWINT-1:0] w_hw_sync;
    logic [5:0]           w_hw6;
    logic [7:0]           w_ip;
    logic                 w_int;
    logic                 w_tick;
    logic                 w_cnt_wr;
    logic                 w_cmp_wr;
    logic [31:0]          w_count_inc;
    logic [31:0]          w_sr;
    logic [31:0]          w_cause;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0][NUM_HWINT-1:0] r_sync;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sync <= '0;
            end else begin
                r_sync[0] <= HWInt;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end

        assign w_hw_sync = r_sync[SYNC_STAGES-1];
    end else begin : g_bypass
        assign w_hw_sync = HWInt;
    end

    assign w_hw6       = 6'(w_hw_sync);
    assign w_ip        = {r_ip_hw, r_ip_sw};
    assign w_int       = r_ie & ~r_exl & (|(w_ip & r_im));
    assign w_tick      = (r_pre == c_PRE_LAST);
    assign w_cnt_wr    = en && (CP0ADD == 5'd9);
    assign w_cmp_wr    = en && (CP0ADD == 5'd11);
    assign w_count_inc = r_count + 32'd1;

    assign Req      = w_int | EXLSet;
    assign TimerIrq = r_ti;
    assign EPCOut   = r_epc;

    // Interrupt beats exception beats ERET beats mtc0 for the status fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_badvaddr <= '0;
            r_epc      <= '0;
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= '0;
            r_bd       <= 1'b0;
            r_ip_hw    <= '0;
            r_ip_sw    <= '0;
            r_exccode  <= '0;
        end else begin
            r_ip_hw <= w_hw6 | {r_ti, 5'b0};
            if (w_int || EXLSet) begin
                r_exl     <= 1'b1;
                r_bd      <= BDIn;
                r_epc     <= BDIn ? (VPC - 32'd4) : VPC;
                r_exccode <= w_int ? 5'd0 : ExcCodeIn;
                if (!w_int && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) begin
                    r_badvaddr <= VAddr;
                end
            end else if (EXLClr) begin
                r_exl <= 1'b0;
            end else if (en) begin
                case (CP0ADD)
                    5'd12: begin
                        r_ie  <= CP0In[0];
                        r_exl <= CP0In[1];
                        r_im  <= CP0In[15:8];
                    end
                    5'd13:   r_ip_sw <= CP0In[9:8];
                    5'd14:   r_epc   <= CP0In;
                    default: ;
                endcase
            end
        end
    end

    // Count/Compare writes bypass arbitration; a Compare write clears TI even on a match.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre     <= '0;
            r_count   <= '0;
            r_compare <= 32'hFFFF_FFFF;
            r_ti      <= 1'b0;
        end else begin
            if (w_cnt_wr) begin
                r_count <= CP0In;
                r_pre   <= '0;
            end else if (w_tick) begin
                r_count <= w_count_inc;
                r_pre   <= '0;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
            if (w_cmp_wr) begin
                r_compare <= CP0In;
            end
            if (w_cmp_wr) begin
                r_ti <= 1'b0;
            end else if (!w_cnt_wr && w_tick && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_sr    = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};

    always_comb begin
        CP0Out = '0;
        case (CP0ADD)
            5'd8:    CP0Out = r_badvaddr;
            5'd9:    CP0Out = r_count;
            5'd11:   CP0Out = r_compare;
            5'd12:   CP0Out = w_sr;
            5'd13:   CP0Out = w_cause;
            5'd14:   CP0Out = r_epc;
            5'd15:   CP0Out = PRID;
            default: CP0Out = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cp0_irq_ctrl.sv
// ============================================================================
// Module   : tb_cp0_irq_ctrl
// Purpose  : Directed self-checking bench for cp0_irq_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_irq_ctrl;

    localparam logic [31:0] c_PRID = 32'h0001_8000;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset_n = 1'b1;
    logic        en = 1'b0;
    logic [4:0]  CP0ADD = '0;
    logic [31:0] CP0In = '0;
    logic        EXLSet = 1'b0;
    logic [4:0]  ExcCodeIn = '0;
    logic [31:0] VPC = 32'h2000;
    logic [31:0] VAddr = '0;
    logic        BDIn = 1'b0;
    logic [5:0]  HWInt = '0;
    logic        EXLClr = 1'b0;

    logic [31:0] CP0Out, EPCOut, CP0Out1, EPCOut1;
    logic        Req, TimerIrq, Req1, TimerIrq1;

    int checks = 0;
    int failures = 0;

    cp0_irq_ctrl #(.NUM_HWINT(6), .SYNC_STAGES(2), .COUNT_DIV(4), .PRID(c_PRID)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .CP0ADD(CP0ADD), .CP0In(CP0In),
        .CP0Out(CP0Out), .EXLSet(EXLSet), .ExcCodeIn(ExcCodeIn), .VPC(VPC),
        .VAddr(VAddr), .BDIn(BDIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .EPCOut(EPCOut), .Req(Req), .TimerIrq(TimerIrq)
    );

    cp0_irq_ctrl #(.NUM_HWINT(6), .SYNC_STAGES(2), .COUNT_DIV(1), .PRID(c_PRID)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .CP0ADD(CP0ADD), .CP0In(CP0In),
        .CP0Out(CP0Out1), .EXLSet(EXLSet), .ExcCodeIn(ExcCodeIn), .VPC(VPC),
        .VAddr(VAddr), .BDIn(BDIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .EPCOut(EPCOut1), .Req(Req1), .TimerIrq(TimerIrq1)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_old;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
    } wr_vec_t;

    rd_vec_t rv[10];
    wr_vec_t wv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        CP0ADD = a;
        #1;
        d = CP0Out;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        en = 1'b1;
        CP0ADD = a;
        CP0In = d;
        step();
        en = 1'b0;
    endtask

    initial begin
        logic [31:0] v;

        rv[0] = '{5'd8,  32'h0};
        rv[1] = '{5'd9,  32'h0};
        rv[2] = '{5'd10, 32'h0};
        rv[3] = '{5'd11, 32'hFFFF_FFFF};
        rv[4] = '{5'd12, 32'h0040_0000};
        rv[5] = '{5'd13, 32'h0};
        rv[6] = '{5'd14, 32'h0};
        rv[7] = '{5'd15, c_PRID};
        rv[8] = '{5'd0,  32'h0};
        rv[9] = '{5'd31, 32'h0};

        wv[0] = '{5'd14, 32'h1234_5678, 1'b1, 32'h0,         32'h1234_5678};
        wv[1] = '{5'd8,  32'h0000_DEAD, 1'b1, 32'h0,         32'h0};
        wv[2] = '{5'd15, 32'h0000_0000, 1'b1, c_PRID,        c_PRID};
        wv[3] = '{5'd12, 32'hFFFF_FFFF, 1'b1, 32'h0040_0000, 32'h0040_FF03};
        wv[4] = '{5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h0000_0300};
        wv[5] = '{5'd13, 32'h0000_0000, 1'b1, 32'h0000_0300, 32'h0};
        wv[6] = '{5'd12, 32'h0000_0000, 1'b1, 32'h0040_FF03, 32'h0040_0000};
        wv[7] = '{5'd9,  32'd100,       1'b0, 32'h0,         32'd100};
        wv[8] = '{5'd11, 32'h0000_0055, 1'b1, 32'hFFFF_FFFF, 32'h0000_0055};

        // Reset with the clock stopped
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            rd(rv[i].addr, v);
            chk($sformatf("reset_rd[%0d]", rv[i].addr), v, rv[i].exp);
        end
        chk("reset_req", {31'd0, Req}, 32'd0);
        chk("reset_ti", {31'd0, TimerIrq}, 32'd0);
        chk("reset_epcout", EPCOut, 32'd0);

        clk_run = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        CP0ADD = 5'd9;
        #1;
        chk("count_div1_after5", CP0Out1, 32'd5);
        chk("count_div4_after5", CP0Out, 32'd1);

        // mtc0 write / read-back table
        for (int i = 0; i < 9; i++) begin
            en = 1'b1;
            CP0ADD = wv[i].addr;
            CP0In = wv[i].data;
            #1;
            if (wv[i].chk_old) chk($sformatf("wr_old[%0d]", i), CP0Out, wv[i].exp_old);
            step();
            en = 1'b0;
            #1;
            chk($sformatf("wr_new[%0d]", i), CP0Out, wv[i].exp_new);
        end

        // Hardware interrupt through the synchroniser
        wr(5'd12, 32'h0000_0401);
        HWInt = 6'b000001;
        step();
        chk("irq_lat1", {31'd0, Req}, 32'd0);
        step();
        chk("irq_lat2", {31'd0, Req}, 32'd0);
        step();
        chk("irq_lat3", {31'd0, Req}, 32'd1);
        step();
        chk("irq_epc", EPCOut, 32'h2000);
        chk("irq_req_after", {31'd0, Req}, 32'd0);
        rd(5'd13, v);
        chk("irq_cause", v, 32'h0000_0400);
        rd(5'd12, v);
        chk("irq_sr", v, 32'h0040_0403);
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        chk("eret_req_again", {31'd0, Req}, 32'd1);
        HWInt = 6'b0;
        step();
        wr(5'd12, 32'h0);

        // Delay-slot exception colliding with an EPC write
        EXLSet = 1'b1; ExcCodeIn = 5'd4; BDIn = 1'b1; VPC = 32'h3004; VAddr = 32'h1235;
        en = 1'b1; CP0ADD = 5'd14; CP0In = 32'hAAAA_AAAA;
        #1;
        chk("exc_req_comb", {31'd0, Req}, 32'd1);
        step();
        EXLSet = 1'b0; en = 1'b0; BDIn = 1'b0;
        chk("exc_epc", EPCOut, 32'h3000);
        rd(5'd8, v);
        chk("exc_badvaddr", v, 32'h1235);
        rd(5'd13, v);
        chk("exc_cause", v, 32'h8000_0010);
        rd(5'd12, v);
        chk("exc_sr", v, 32'h0040_0002);
        EXLSet = 1'b1; ExcCodeIn = 5'd12; VAddr = 32'h9999; VPC = 32'h4000;
        step();
        EXLSet = 1'b0;
        rd(5'd8, v);
        chk("exc12_badvaddr_kept", v, 32'h1235);
        rd(5'd13, v);
        chk("exc12_cause", v, 32'h0000_0030);
        chk("exc12_epc", EPCOut, 32'h4000);
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;

        // Prescaled timer, COUNT_DIV=4
        wr(5'd9, 32'd0);
        wr(5'd11, 32'd3);
        wr(5'd12, 32'h0000_8001);
        for (int i = 0; i < 9; i++) step();
        chk("timer_ti_edge11", {31'd0, TimerIrq}, 32'd0);
        step();
        chk("timer_ti_edge12", {31'd0, TimerIrq}, 32'd1);
        chk("timer_req_edge12", {31'd0, Req}, 32'd0);
        step();
        chk("timer_req_edge13", {31'd0, Req}, 32'd1);
        rd(5'd13, v);
        chk("timer_cause", v, 32'h4000_8030);
        step();
        chk("timer_req_taken", {31'd0, Req}, 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("timer_ti_held", {31'd0, TimerIrq}, 32'd1);
        wr(5'd11, 32'hFFFF_FFF0);
        chk("timer_ti_cleared", {31'd0, TimerIrq}, 32'd0);
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        chk("timer_req_dropped", {31'd0, Req}, 32'd0);
        rd(5'd12, v);
        chk("timer_sr", v, 32'h0040_8001);
        wr(5'd12, 32'h0);

        // Wrap match and Compare-write collision
        wr(5'd11, 32'd0);
        wr(5'd9, 32'd0);
        chk("load_equal_no_ti", {31'd0, TimerIrq}, 32'd0);
        wr(5'd9, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) step();
        chk("wrap_ti_before", {31'd0, TimerIrq}, 32'd0);
        step();
        chk("wrap_ti_set", {31'd0, TimerIrq}, 32'd1);
        rd(5'd9, v);
        chk("wrap_count", v, 32'd0);
        wr(5'd11, 32'd0);
        wr(5'd9, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) step();
        wr(5'd11, 32'd0);
        chk("collide_ti", {31'd0, TimerIrq}, 32'd0);
        rd(5'd9, v);
        chk("collide_count", v, 32'd0);
        step();
        chk("collide_ti_later", {31'd0, TimerIrq}, 32'd0);

        // Masking by IE and EXL
        wr(5'd12, 32'h0000_FC00);
        HWInt = 6'h3F;
        for (int i = 0; i < 3; i++) step();
        chk("mask_ie0_req", {31'd0, Req}, 32'd0);
        rd(5'd13, v);
        chk("mask_cause_ip", v, 32'h0000_FC00);
        wr(5'd12, 32'h0000_FC03);
        chk("mask_exl1_req", {31'd0, Req}, 32'd0);
        wr(5'd12, 32'h0000_FC01);
        chk("unmask_req", {31'd0, Req}, 32'd1);
        step();

        // Asynchronous reset in the middle of the handler
        #3 reset_n = 1'b0;
        #1;
        chk("areset_req", {31'd0, Req}, 32'd0);
        chk("areset_epc", EPCOut, 32'd0);
        rd(5'd12, v);
        chk("areset_sr", v, 32'h0040_0000);
        rd(5'd11, v);
        chk("areset_compare", v, 32'hFFFF_FFFF);
        step();
        reset_n = 1'b1;
        HWInt = 6'h0;
        rd(5'd15, v);
        chk("prid", v, c_PRID);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
